// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// error codes, FSM states and the accept-time error classifier.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // Illegal encodings win over misalignment.
  function automatic err_t classify(input logic is_store, input logic [2:0] funct3,
                                    input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    illegal = is_store ? (funct3[2] || (funct3[1:0] == 2'b11))
                       : ((funct3[1:0] == 2'b11) || (funct3 == 3'b110));
    misaligned = ((funct3[1:0] == SZ_H) && lane[0]) ||
                 ((funct3[1:0] == SZ_W) && (lane != 2'b00));
    if (illegal) return ERR_ILLEGAL;
    if (misaligned) return ERR_MISALIGN;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side and memory-side bundles of the LSU; master drives the request.
interface lsu_core_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            is_store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rdata;
  logic [1:0]      err;
  logic            busy;

  modport master (output req_valid, is_store, funct3, addr, wdata,
                  input  req_ready, rsp_valid, rdata, err, busy);
  modport slave  (input  req_valid, is_store, funct3, addr, wdata,
                  output req_ready, rsp_valid, rdata, err, busy);
endinterface

interface lsu_mem_if;
  import lsu_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Lane logic: byte enables, store-data replication and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c
);

  logic [XLEN-1:0] shifted_c;

  always_comb begin
    shifted_c = rword >> {lane, 3'b000};
    be_c      = 4'b1111;
    wdata_c   = wdata;
    rdata_c   = shifted_c;
    case (funct3[1:0])
      SZ_B: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = funct3[2] ? {24'b0, shifted_c[7:0]} : {{24{shifted_c[7]}}, shifted_c[7:0]};
      end
      SZ_H: begin
        be_c    = 4'b0011 << lane;
        wdata_c = {2{wdata[15:0]}};
        rdata_c = funct3[2] ? {16'b0, shifted_c[15:0]} : {{16{shifted_c[15]}}, shifted_c[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding op, request/grant bus with
// separate read-data return, per-op timeout and registered outputs.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_core_if.slave core,
  lsu_mem_if.master mem
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] cnt;

  logic [2:0]      al_funct3_c;
  logic [1:0]      al_lane_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] rdata_c;
  err_t            acc_err_c;
  logic            cnt_hit_c;

  // Aligner sees the incoming op while idle, the captured op afterwards.
  always_comb begin
    al_funct3_c = (state == ST_IDLE) ? core.funct3 : funct3_q;
    al_lane_c   = (state == ST_IDLE) ? core.addr[1:0] : lane_q;
    acc_err_c   = classify(core.is_store, core.funct3, core.addr[1:0]);
    cnt_hit_c   = (cnt >= CNT_LAST);
  end

  lsu_align u_align (
    .funct3  (al_funct3_c),
    .lane    (al_lane_c),
    .wdata   (core.wdata),
    .rword   (mem.mem_rdata),
    .be_c    (be_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      lane_q         <= 2'b00;
      cnt            <= '0;
      core.req_ready <= 1'b1;
      core.rsp_valid <= 1'b0;
      core.rdata     <= '0;
      core.err       <= ERR_OK;
      core.busy      <= 1'b0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_be     <= '0;
      mem.mem_wdata  <= '0;
    end else begin
      core.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core.req_valid && core.req_ready) begin
            is_store_q     <= core.is_store;
            funct3_q       <= core.funct3;
            lane_q         <= core.addr[1:0];
            cnt            <= '0;
            core.rdata     <= '0;
            core.err       <= acc_err_c;
            core.req_ready <= 1'b0;
            core.busy      <= 1'b1;
            mem.mem_we     <= core.is_store;
            mem.mem_addr   <= {core.addr[XLEN-1:2], 2'b00};
            mem.mem_be     <= be_c;
            mem.mem_wdata  <= wdata_c;
            if (acc_err_c != ERR_OK) begin
              state          <= ST_RESP;
              core.rsp_valid <= 1'b1;
            end else begin
              state       <= ST_REQ;
              mem.mem_req <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt) begin
            mem.mem_req <= 1'b0;
            cnt         <= cnt + CNT_W'(1);
            if (is_store_q) begin
              state          <= ST_RESP;
              core.rsp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end else if (cnt_hit_c) begin
            state          <= ST_RESP;
            mem.mem_req    <= 1'b0;
            core.err       <= ERR_TIMEOUT;
            core.rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // A grant on the budget's last cycle still earns one data cycle here.
          if (mem.mem_rvalid) begin
            state          <= ST_RESP;
            core.rdata     <= rdata_c;
            core.rsp_valid <= 1'b1;
          end else if (cnt_hit_c) begin
            state          <= ST_RESP;
            core.err       <= ERR_TIMEOUT;
            core.rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state          <= ST_IDLE;
          core.busy      <= 1'b0;
          core.req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized ops
// scored against a timing/data model of the unit's externally visible rules.
module tb_lsu;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  lsu_core_if core_if ();
  lsu_mem_if  mem_if ();

  lsu #(.TIMEOUT_CYCLES(T)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .mem  (mem_if)
  );

  always #5 clk = ~clk;

  // Observations of one op
  int          o_n, o_rsp_cnt, o_req_cyc, o_busy_bad;
  logic [1:0]  o_err;
  logic [31:0] o_rdata, o_maddr, o_mwdata;
  logic [3:0]  o_mbe;
  logic        o_mwe, o_ready_pre, o_idle_after;

  // Model expectations of one op
  int          e_n, e_req_cyc;
  logic [1:0]  e_err;
  logic [31:0] e_rdata, e_maddr, e_mwdata;
  logic [3:0]  e_mbe;

  // g/r: edge index after accept at which gnt / rvalid are presented
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] mrd,
                                input int g, input int r);
    int nb;
    int dl;
    logic legal;
    logic [31:0] mask, sh, v;
    nb    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mask  = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
    e_maddr  = a & ~32'h3;
    e_mbe    = 4'(((1 << nb) - 1) << int'(a[1:0]));
    e_mwdata = (wd & mask) * ((nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'h1);
    e_rdata = '0; e_req_cyc = 0; e_err = 2'b00;
    if (!legal) begin
      e_err = 2'b11; e_n = 1;
    end else if ((int'(a[1:0]) % nb) != 0) begin
      e_err = 2'b01; e_n = 1;
    end else if (g > T) begin
      e_err = 2'b10; e_n = T + 1; e_req_cyc = T;
    end else begin
      e_req_cyc = g;
      if (st) e_n = g + 1;
      else begin
        dl = (g + 1 > T) ? g + 1 : T;
        if (r <= dl) begin
          e_n = r + 1;
          sh  = mrd >> (8 * int'(a[1:0]));
          v   = sh & mask;
          if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
          e_rdata = v;
        end else begin
          e_n = dl + 1; e_err = 2'b10;
        end
      end
    end
  endfunction

  // Drives one op and records what the DUT did; bounded to 40 cycles.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] mrd,
                        input int g, input int r, input bit noise);
    o_n = 0; o_rsp_cnt = 0; o_req_cyc = 0; o_busy_bad = 0; o_idle_after = 1'b0;
    o_err = '0; o_rdata = '0; o_maddr = '0; o_mwdata = '0; o_mbe = '0; o_mwe = 1'b0;
    @(negedge clk);
    core_if.req_valid = 1'b1; core_if.is_store = st; core_if.funct3 = f3;
    core_if.addr = a; core_if.wdata = wd; mem_if.mem_rdata = mrd;
    o_ready_pre = core_if.req_ready;
    @(posedge clk);
    #1;
    if (noise) begin
      core_if.is_store = 1'($urandom); core_if.funct3 = 3'($urandom);
      core_if.addr = $urandom; core_if.wdata = $urandom; core_if.req_valid = 1'($urandom);
    end else core_if.req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (core_if.rsp_valid) begin
        o_rsp_cnt++;
        if (o_n == 0) begin o_n = n; o_err = core_if.err; o_rdata = core_if.rdata; end
      end
      if (mem_if.mem_req) begin
        if (o_req_cyc == 0) begin
          o_maddr = mem_if.mem_addr; o_mbe = mem_if.mem_be;
          o_mwdata = mem_if.mem_wdata; o_mwe = mem_if.mem_we;
        end
        o_req_cyc++;
      end
      if ((o_n == 0 || o_n == n) && !core_if.busy) o_busy_bad++;
      if (o_n != 0 && n == o_n + 1) begin
        o_idle_after = !core_if.busy && core_if.req_ready;
        break;
      end
      mem_if.mem_gnt    = (o_n == 0) && (n == g);
      mem_if.mem_rvalid = (o_n == 0) && ((n == r) || (noise && n <= g && ($urandom % 2 == 0)));
      if (o_n != 0) core_if.req_valid = 1'b0;
      else if (noise) core_if.req_valid = 1'($urandom);
    end
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; core_if.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({core_if.req_ready, core_if.busy, core_if.rsp_valid, mem_if.mem_req, mem_if.mem_we} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=10000",
        {core_if.req_ready, core_if.busy, core_if.rsp_valid, mem_if.mem_req, mem_if.mem_we});
    end
    total++;
    if ({mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata, core_if.rdata, core_if.err} !== '0) begin
      bad++; $display("FAIL reset_data got addr=%h be=%b wdata=%h rdata=%h err=%b want all zero",
        mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata, core_if.rdata, core_if.err);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2, 1'b0);
    total++; if (o_ready_pre !== 1'b1) begin bad++; $display("FAIL lw_ready got=%b want=1", o_ready_pre); end
    total++; if (o_n !== 3) begin bad++; $display("FAIL lw_latency got=%0d want=3", o_n); end
    total++; if (o_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", o_rdata); end
    total++; if (o_err !== 2'b00) begin bad++; $display("FAIL lw_err got=%b want=00", o_err); end
    total++; if (o_req_cyc !== 1 || o_maddr !== 32'h100 || o_mwe !== 1'b0 || o_mbe !== 4'b1111) begin
      bad++; $display("FAIL lw_bus got cyc=%0d addr=%h we=%b be=%b want 1/100/0/1111", o_req_cyc, o_maddr, o_mwe, o_mbe);
    end
    total++; if (o_idle_after !== 1'b1) begin bad++; $display("FAIL lw_idle got=%b want=1", o_idle_after); end
  endtask

  task automatic test_load_byte();
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 2, 1'b0);
    total++; if (o_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h want=ffffff80", o_rdata); end
    total++; if (o_mbe !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b want=1000", o_mbe); end
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 3, 1'b0);
    total++; if (o_rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_rdata got=%h want=00000080", o_rdata); end
    total++; if (o_n !== 4) begin bad++; $display("FAIL lbu_latency got=%0d want=4", o_n); end
  endtask

  task automatic test_store_half();
    run_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 99, 1'b0);
    total++; if (o_mbe !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b want=1100", o_mbe); end
    total++; if (o_mwdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%h want=abcdabcd", o_mwdata); end
    total++; if (o_maddr !== 32'h200 || o_mwe !== 1'b1) begin
      bad++; $display("FAIL sh_addr got addr=%h we=%b want 200/1", o_maddr, o_mwe);
    end
    total++; if (o_n !== 2 || o_err !== 2'b00 || o_rdata !== 32'h0) begin
      bad++; $display("FAIL sh_rsp got n=%0d err=%b rdata=%h want 2/00/0", o_n, o_err, o_rdata);
    end
  endtask

  task automatic test_errors();
    run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 2, 1'b0);
    total++; if (o_n !== 1 || o_err !== 2'b01 || o_req_cyc !== 0) begin
      bad++; $display("FAIL misalign got n=%0d err=%b reqcyc=%0d want 1/01/0", o_n, o_err, o_req_cyc);
    end
    run_op(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1, 2, 1'b0);
    total++; if (o_n !== 1 || o_err !== 2'b11 || o_req_cyc !== 0) begin
      bad++; $display("FAIL illegal_ld got n=%0d err=%b reqcyc=%0d want 1/11/0", o_n, o_err, o_req_cyc);
    end
    run_op(1'b1, 3'b101, 32'h301, 32'h0, 32'h0, 1, 2, 1'b0);
    total++; if (o_err !== 2'b11 || o_rsp_cnt !== 1) begin
      bad++; $display("FAIL illegal_prio got err=%b rsp=%0d want 11/1", o_err, o_rsp_cnt);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 100, 101, 1'b0);
    total++; if (o_n !== T + 1 || o_err !== 2'b10 || o_rdata !== 32'h0) begin
      bad++; $display("FAIL timeout got n=%0d err=%b rdata=%h want %0d/10/0", o_n, o_err, o_rdata, T + 1);
    end
    total++; if (o_req_cyc !== T || o_busy_bad !== 0) begin
      bad++; $display("FAIL timeout_req got reqcyc=%0d busybad=%0d want %0d/0", o_req_cyc, o_busy_bad, T);
    end
    run_op(1'b1, 3'b010, 32'h44, 32'h5555AAAA, 32'h0, T, 0, 1'b0);
    total++; if (o_err !== 2'b00 || o_n !== T + 1) begin
      bad++; $display("FAIL gnt_wins got err=%b n=%0d want 00/%0d", o_err, o_n, T + 1);
    end
  endtask

  task automatic test_reset_mid_op();
    int rsp_seen;
    rsp_seen = 0;
    @(negedge clk);
    core_if.req_valid = 1'b1; core_if.is_store = 1'b0; core_if.funct3 = 3'b010;
    core_if.addr = 32'h100; core_if.wdata = 32'h0; mem_if.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    core_if.req_valid = 1'b0; mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    total++; if (core_if.busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", core_if.busy); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({core_if.req_ready, core_if.busy, core_if.rsp_valid, mem_if.mem_req, mem_if.mem_we} !== 5'b10000 ||
        {mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata, core_if.rdata, core_if.err} !== '0) begin
      bad++; $display("FAIL rst_async got ready=%b busy=%b req=%b addr=%h want 1/0/0/0",
        core_if.req_ready, core_if.busy, mem_if.mem_req, mem_if.mem_addr);
    end
    mem_if.mem_rvalid = 1'b1;
    repeat (2) begin @(negedge clk); if (core_if.rsp_valid) rsp_seen++; end
    rst = 1'b0; mem_if.mem_rvalid = 1'b0;
    repeat (2) begin @(negedge clk); if (core_if.rsp_valid) rsp_seen++; end
    total++; if (rsp_seen !== 0) begin bad++; $display("FAIL rst_no_rsp got=%0d want=0", rsp_seen); end
    run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 1, 2, 1'b0);
    total++; if (o_n !== 3 || o_err !== 2'b00 || o_rdata !== 32'hFFFF_8001) begin
      bad++; $display("FAIL rst_next_op got n=%0d err=%b rdata=%h want 3/00/ffff8001", o_n, o_err, o_rdata);
    end
  endtask

  task automatic test_random();
    logic st;
    logic [2:0] f3;
    logic [31:0] a, wd, mrd;
    int g, r;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom);
      if ($urandom % 4 == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom % 3);
      else begin
        f3 = 3'($urandom % 5);
        if (f3 > 3'd2) f3 = f3 + 3'd1;
      end
      a = $urandom;
      if ($urandom % 2 == 0) a = a & ~32'h3;
      wd = $urandom; mrd = $urandom;
      g = int'($urandom_range(6, 1));
      r = g + int'($urandom_range(3, 1));
      model(st, f3, a, wd, mrd, g, r);
      run_op(st, f3, a, wd, mrd, g, r, 1'b1);
      total++; if (o_n !== e_n || o_err !== e_err || o_rdata !== e_rdata) begin
        bad++; $display("FAIL rnd_rsp[%0d] st=%b f3=%b a=%h g=%0d r=%0d got n=%0d err=%b rd=%h want n=%0d err=%b rd=%h",
          i, st, f3, a, g, r, o_n, o_err, o_rdata, e_n, e_err, e_rdata);
      end
      total++; if (o_rsp_cnt !== 1 || o_req_cyc !== e_req_cyc || o_busy_bad !== 0 || o_idle_after !== 1'b1 || o_ready_pre !== 1'b1) begin
        bad++; $display("FAIL rnd_ctl[%0d] got rsp=%0d reqcyc=%0d busybad=%0d idle=%b ready=%b want 1/%0d/0/1/1",
          i, o_rsp_cnt, o_req_cyc, o_busy_bad, o_idle_after, o_ready_pre, e_req_cyc);
      end
      if (e_req_cyc > 0) begin
        total++; if (o_maddr !== e_maddr || o_mbe !== e_mbe || o_mwe !== st || (st && o_mwdata !== e_mwdata)) begin
          bad++; $display("FAIL rnd_bus[%0d] got addr=%h be=%b we=%b wd=%h want addr=%h be=%b we=%b wd=%h",
            i, o_maddr, o_mbe, o_mwe, o_mwdata, e_maddr, e_mbe, st, e_mwdata);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    core_if.req_valid = 1'b0; core_if.is_store = 1'b0; core_if.funct3 = 3'b000;
    core_if.addr = '0; core_if.wdata = '0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_errors();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles in REQ+WAIT before a timeout error; legal range 1..255.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core presents a memory op.
REQ-005 req_ready  output  1  LSU accepts op (high only in IDLE).
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-008 addr  input  32  effective address, ALU result (rs1 + imm).
REQ-009 wdata  input  32  store data (rs2).
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  aligned, extended load data.
REQ-012 err  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-013 busy  output  1  high whenever state != IDLE; core stall.
REQ-014 mem_req  output  1  bus request, held until grant.
REQ-015 mem_we  output  1  1 = write.
REQ-016 mem_addr  output  32  {addr[31:2], 2'b00}.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_gnt  input  1  request accepted this cycle.
REQ-020 mem_rvalid  input  1  read data valid.
REQ-021 mem_rdata  input  32  read word.

Function
REQ-022 FSM states IDLE, REQ, WAIT, RESP; all outputs driven from registers.
REQ-023 Accept on req_valid & req_ready: capture is_store, funct3, addr, wdata; compute err class.
REQ-024 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 (loads 011/110/111, stores 011..111) -> IDLE to RESP directly, mem_req never asserted; illegal takes priority over misaligned.
REQ-025 Valid op -> REQ; mem_req high from the cycle after accept until the cycle mem_gnt is sampled high.
REQ-026 mem_be: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111.
REQ-027 mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-028 Store: gnt in REQ -> RESP. Load: gnt in REQ -> WAIT; mem_rvalid in WAIT -> RESP with rdata latched.
REQ-029 mem_rvalid outside WAIT ignored (memory returns data at least one cycle after gnt).
REQ-030 Load extract: lane = addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-031 RESP lasts exactly one cycle with rsp_valid=1, then IDLE; rdata=0 for stores and errors.
REQ-032 Timeout counter clears on accept, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES -> RESP, err=10, mem_req dropped.
REQ-033 Same-cycle gnt/rvalid and timeout hit: gnt/rvalid wins, err=00.
REQ-034 Minimum latency accept-to-rsp_valid: error 1 cycle, store 2, load 3.
REQ-035 req_valid while busy is ignored; no queuing.

Reset
REQ-036 rst asynchronously forces IDLE; req_ready=1; rsp_valid, busy, mem_req, mem_we=0; mem_addr, mem_be, mem_wdata, rdata=0; err=00; counter=0.
REQ-037 Reset mid-operation aborts the op; no rsp_valid for it.

Structure
REQ-038 Package lsu_pkg holds funct3 constants, err codes, FSM state enum.
REQ-039 Sub-module lsu_align: combinational byte-enable, store replication, load extract/extend.

Verification
REQ-040 LW addr 0x100, gnt next cycle, rvalid one later, mem_rdata 0xDEADBEEF -> rdata 0xDEADBEEF, err 00, rsp_valid 3 cycles after accept.
REQ-041 LB addr 0x103, mem_rdata 0x80FF_0000 -> rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-042 SH addr 0x202 wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_addr 0x200, mem_we 1.
REQ-043 LW addr 0x101 -> no mem_req, err 01 one cycle after accept; funct3 111 load -> err 11.
REQ-044 TIMEOUT_CYCLES=4, gnt never asserted -> mem_req falls, err 10, rsp_valid after 4 busy cycles.
REQ-045 rst pulsed while in WAIT -> outputs at reset values immediately, no rsp_valid, next op completes normally.
